// File: rtl/vga_pll_lock_ctrl.sv
// PLL lock sequencer: pulses the PLL reset, waits for a stable lock and releases the pixel-domain reset.
// Optional lock-loss counter is built when VGA_PLL_LOSS_CNT_EN is defined.
module vga_pll_lock_ctrl #(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 50000,
    parameter int LOCK_STABLE  = 256,
    parameter int MAX_RETRIES  = 3
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       force_relock,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fault,
    output logic [1:0] state,
    output logic [3:0] retry_cnt,
    output logic [7:0] loss_cnt
);

    typedef enum logic [1:0] {
        ST_RESET     = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_RUN       = 2'd2,
        ST_FAULT     = 2'd3
    } state_t;

    localparam int RW = $clog2(RST_CYCLES + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    localparam int SW = $clog2(LOCK_STABLE + 1);

    localparam logic [RW-1:0] RST_LAST    = RW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST     = TW'(LOCK_TIMEOUT - 1);
    localparam logic [SW-1:0] STABLE_LAST = SW'(LOCK_STABLE - 1);
    localparam logic [3:0]    RETRY_MAX   = 4'(MAX_RETRIES);

    state_t          state_q, state_d;
    logic [RW-1:0]   rst_cnt_q, rst_cnt_d;
    logic [TW-1:0]   to_cnt_q, to_cnt_d;
    logic [SW-1:0]   stable_q, stable_d;
    logic [3:0]      retry_q, retry_d;
    logic            sync1, lock_sync;

    // pll_locked is asynchronous; only lock_sync is used downstream.
    always_ff @(posedge refclk) begin
        if (rst) begin
            sync1     <= 1'b0;
            lock_sync <= 1'b0;
        end else begin
            sync1     <= pll_locked;
            lock_sync <= sync1;
        end
    end

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        to_cnt_d  = to_cnt_q;
        stable_d  = stable_q;
        retry_d   = retry_q;
        if (force_relock) begin
            state_d   = ST_RESET;
            rst_cnt_d = '0;
            retry_d   = '0;
        end else begin
            case (state_q)
                ST_RESET: begin
                    if (rst_cnt_q == RST_LAST) begin
                        state_d  = ST_WAIT_LOCK;
                        to_cnt_d = '0;
                        stable_d = '0;
                    end else begin
                        rst_cnt_d = rst_cnt_q + RW'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    // A lock completing on the timeout cycle takes priority over the timeout.
                    if (lock_sync && stable_q == STABLE_LAST) begin
                        state_d = ST_RUN;
                        retry_d = '0;
                    end else if (to_cnt_q == TO_LAST) begin
                        if (retry_q < RETRY_MAX) begin
                            state_d   = ST_RESET;
                            rst_cnt_d = '0;
                            retry_d   = retry_q + 4'd1;
                        end else begin
                            state_d = ST_FAULT;
                        end
                    end else begin
                        to_cnt_d = to_cnt_q + TW'(1);
                        stable_d = lock_sync ? stable_q + SW'(1) : '0;
                    end
                end
                ST_RUN: begin
                    if (!lock_sync) begin
                        state_d   = ST_RESET;
                        rst_cnt_d = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output flags decode the next state so they move together with the state register.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q   <= ST_RESET;
            rst_cnt_q <= '0;
            to_cnt_q  <= '0;
            stable_q  <= '0;
            retry_q   <= '0;
            pll_rst   <= 1'b1;
            sys_rst   <= 1'b1;
            ready     <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
            to_cnt_q  <= to_cnt_d;
            stable_q  <= stable_d;
            retry_q   <= retry_d;
            pll_rst   <= (state_d == ST_RESET) || (state_d == ST_FAULT);
            sys_rst   <= (state_d != ST_RUN);
            ready     <= (state_d == ST_RUN);
            fault     <= (state_d == ST_FAULT);
        end
    end

    assign state     = state_q;
    assign retry_cnt = retry_q;

`ifdef VGA_PLL_LOSS_CNT_EN
    logic [7:0] loss_q;

    always_ff @(posedge refclk) begin
        if (rst) begin
            loss_q <= '0;
        end else if (!force_relock && state_q == ST_RUN && !lock_sync && loss_q != 8'hFF) begin
            loss_q <= loss_q + 8'd1;
        end
    end

    assign loss_cnt = loss_q;
`else
    assign loss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_vga_pll_lock_ctrl.sv
// Bench for vga_pll_lock_ctrl: a phase/age model of the lock sequence feeds an expected queue
// that is compared every cycle, plus literal checkpoints on the documented sequences.
module tb_vga_pll_lock_ctrl;

    localparam int RST_CYCLES   = 4;
    localparam int LOCK_TIMEOUT = 100;
    localparam int LOCK_STABLE  = 8;
    localparam int MAX_RETRIES  = 2;
    localparam int EW           = 18;
`ifdef VGA_PLL_LOSS_CNT_EN
    localparam int LOSS_EN = 1;
`else
    localparam int LOSS_EN = 0;
`endif

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       force_relock = 1'b0;
    logic       pll_rst, sys_rst, ready, fault;
    logic [1:0] state;
    logic [3:0] retry_cnt;
    logic [7:0] loss_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    vga_pll_lock_ctrl #(
        .RST_CYCLES  (RST_CYCLES),
        .LOCK_TIMEOUT(LOCK_TIMEOUT),
        .LOCK_STABLE (LOCK_STABLE),
        .MAX_RETRIES (MAX_RETRIES)
    ) dut (
        .refclk      (refclk),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .force_relock(force_relock),
        .pll_rst     (pll_rst),
        .sys_rst     (sys_rst),
        .ready       (ready),
        .fault       (fault),
        .state       (state),
        .retry_cnt   (retry_cnt),
        .loss_cnt    (loss_cnt)
    );

    // clock / watchdog
    always #10 refclk = ~refclk;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d cyc=%0d", name, act, exp, cyc);
        end
    endtask

    // Model: phase (0 reset, 1 wait, 2 run, 3 fault), cycles spent in phase, lock streak.
    int  m_st = 0, m_age = 0, m_streak = 0, m_retry = 0, m_loss = 0;
    bit  hist[$];
    bit  model_ok = 1'b0;
    logic [EW-1:0] exp_q[$];

    always @(posedge refclk) begin : model
        bit ls;
        if (rst) begin
            m_st = 0; m_age = 0; m_streak = 0; m_retry = 0; m_loss = 0;
            hist = '{1'b0, 1'b0};
            model_ok = 1'b1;
        end else if (model_ok) begin
            ls = hist[0];
            if (force_relock) begin
                m_st = 0; m_age = 0; m_retry = 0;
            end else if (m_st == 0) begin
                m_age++;
                if (m_age == RST_CYCLES) begin m_st = 1; m_age = 0; m_streak = 0; end
            end else if (m_st == 1) begin
                m_age++;
                m_streak = ls ? m_streak + 1 : 0;
                if (m_streak == LOCK_STABLE) begin
                    m_st = 2; m_retry = 0;
                end else if (m_age == LOCK_TIMEOUT) begin
                    m_age = 0;
                    if (m_retry < MAX_RETRIES) begin m_retry++; m_st = 0; end
                    else m_st = 3;
                end
            end else if (m_st == 2) begin
                if (!ls) begin
                    m_st = 0; m_age = 0;
                    if (LOSS_EN != 0 && m_loss < 255) m_loss++;
                end
            end
            hist.push_back(pll_locked);
            void'(hist.pop_front());
        end
        if (model_ok)
            exp_q.push_back({2'(m_st), (m_st == 0 || m_st == 3), (m_st != 2), (m_st == 2),
                             (m_st == 3), 4'(m_retry), 8'(m_loss)});
    end

    // scoreboard
    always @(negedge refclk) begin : compare
        logic [EW-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("state",     int'(state),     int'(e[17:16]));
            chk("pll_rst",   int'(pll_rst),   int'(e[15]));
            chk("sys_rst",   int'(sys_rst),   int'(e[14]));
            chk("ready",     int'(ready),     int'(e[13]));
            chk("fault",     int'(fault),     int'(e[12]));
            chk("retry_cnt", int'(retry_cnt), int'(e[11:8]));
            chk("loss_cnt",  int'(loss_cnt),  int'(e[7:0]));
            chk("sys_rst_while_pll_rst", int'(pll_rst && !sys_rst), 0);
        end
    end

    // driver tasks
    task automatic step(input int n);
        repeat (n) begin
            @(posedge refclk);
            @(negedge refclk);
            cyc++;
        end
    endtask

    task automatic do_reset();
        @(negedge refclk);
        rst = 1'b1;
        force_relock = 1'b0;
        @(posedge refclk);
        @(negedge refclk);
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic pin_state(input string name, input int exp);
        chk(name, int'(state), exp);
        chk({name, "_model"}, m_st, exp);
    endtask

    initial begin
        // lock acquisition, lock loss, rst with force_relock
        pll_locked = 1'b0;
        do_reset();
        step(2);  pll_locked = 1'b1;
        step(1);  pin_state("acq_c3", 0); chk("acq_c3_pll_rst", int'(pll_rst), 1);
        step(1);  pin_state("acq_c4", 1); chk("acq_c4_pll_rst", int'(pll_rst), 0);
                  chk("acq_c4_sys_rst", int'(sys_rst), 1);
        step(7);  pin_state("acq_c11", 1); chk("acq_c11_ready", int'(ready), 0);
        step(1);  pin_state("acq_c12", 2); chk("acq_c12_ready", int'(ready), 1);
                  chk("acq_c12_sys_rst", int'(sys_rst), 0); chk("acq_c12_retry", int'(retry_cnt), 0);
        step(3);  pll_locked = 1'b0;
        step(1);  pll_locked = 1'b1;
        step(1);  pin_state("loss_c17", 2);
        step(1);  pin_state("loss_c18", 0); chk("loss_c18_sys_rst", int'(sys_rst), 1);
                  chk("loss_c18_loss", int'(loss_cnt), LOSS_EN);
        step(12); pin_state("relock_c30", 2);
        rst = 1'b1; force_relock = 1'b1;
        step(1);  pin_state("rstfr", 0); chk("rstfr_pll_rst", int'(pll_rst), 1);
                  chk("rstfr_sys_rst", int'(sys_rst), 1); chk("rstfr_ready", int'(ready), 0);
                  chk("rstfr_fault", int'(fault), 0); chk("rstfr_loss", int'(loss_cnt), 0);
        rst = 1'b0; force_relock = 1'b0;

        // force_relock during RESET restarts the pulse
        pll_locked = 1'b0;
        do_reset();
        step(2);  force_relock = 1'b1;
        step(1);  force_relock = 1'b0;
        step(1);  pin_state("frr_c4", 0);
        step(2);  pin_state("frr_c6", 0);
        step(1);  pin_state("frr_c7", 1);

        // no lock: retries then FAULT, then force_relock out of FAULT
        do_reset();
        step(104); pin_state("nolock_c104", 0); chk("nolock_c104_retry", int'(retry_cnt), 1);
        step(104); pin_state("nolock_c208", 0); chk("nolock_c208_retry", int'(retry_cnt), 2);
        step(103); pin_state("nolock_c311", 1);
        step(1);   pin_state("nolock_c312", 3); chk("nolock_c312_fault", int'(fault), 1);
                   chk("nolock_c312_pll_rst", int'(pll_rst), 1); chk("nolock_c312_retry", int'(retry_cnt), 2);
        step(5);   pin_state("fault_hold", 3); chk("fault_hold_pll_rst", int'(pll_rst), 1);
        force_relock = 1'b1;
        step(1);   force_relock = 1'b0;
                   pin_state("fr_fault", 0); chk("fr_fault_retry", int'(retry_cnt), 0);
                   chk("fr_fault_fault", int'(fault), 0); chk("fr_fault_pll_rst", int'(pll_rst), 1);
        step(3);   chk("fr_fault_pll_rst3", int'(pll_rst), 1);
        step(1);   pin_state("fr_fault_wait", 1); chk("fr_fault_pll_rst4", int'(pll_rst), 0);

        // lock toggling every 5 cycles never qualifies
        do_reset();
        while (cyc < 104) begin
            pll_locked = ((cyc / 5) % 2) == 1;
            step(1);
        end
        pin_state("toggle_c104", 0); chk("toggle_c104_retry", int'(retry_cnt), 1);

        // lock completing exactly on the timeout cycle wins
        pll_locked = 1'b0;
        do_reset();
        step(94); pll_locked = 1'b1;
        step(10); pin_state("edge_win", 2); chk("edge_win_retry", int'(retry_cnt), 0);

        // one cycle later the timeout fires first
        pll_locked = 1'b0;
        do_reset();
        step(95); pll_locked = 1'b1;
        step(9);  pin_state("edge_late", 0); chk("edge_late_retry", int'(retry_cnt), 1);

        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
